// File: rtl/seg7_scan.sv
// Multiplexed scanner for a common-anode 7-segment display with double-buffered value,
// anti-ghosting gap cycle and leading-zero suppression; all outputs registered (1-cycle latency).
module seg7_scan #(
  parameter int DIGITS        = 4,
  parameter int DIV           = 1000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   iv_value,
  input  logic [DIGITS-1:0]     iv_dp,
  input  logic                  i_lz_en,
  output logic [3:0]            ov_nibble,
  output logic [DIGITS-1:0]     ov_anode,
  output logic                  o_dp,
  output logic                  o_blank,
  output logic                  o_ack
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow_val, pend_val;
  logic [DIGITS-1:0]     shadow_dp, pend_dp;
  logic                  pend_vld;
  logic [DIGITS-1:0]     anode_oh;

  logic                  tick, last, commit, gap, sup, all_zero;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            cur_nib;

  assign tick    = (presc == PW'(DIV - 1));
  assign last    = (idx == IW'(DIGITS - 1));
  assign commit  = tick && last && pend_vld;
  assign gap     = (presc == '0);
  assign cur_nib = shadow_val[4*idx +: 4];

  // Digit k is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero && (shadow_val[4*k +: 4] == 4'd0);
      lz_mask[k] = i_lz_en && all_zero && !shadow_dp[k];
    end
  end

  assign sup = lz_mask[idx];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc      <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      ov_nibble  <= 4'd0;
      anode_oh   <= '0;
      o_dp       <= 1'b0;
      o_blank    <= 1'b1;
      o_ack      <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= last ? '0 : idx + 1'b1;

      if (commit) begin
        shadow_val <= pend_val;
        shadow_dp  <= pend_dp;
      end

      // A load on the commit edge becomes the next pending value.
      if (i_load) begin
        pend_val <= iv_value;
        pend_dp  <= iv_dp;
        pend_vld <= 1'b1;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end

      ov_nibble <= sup ? 4'd0 : cur_nib;
      anode_oh  <= (gap || sup) ? '0 : (DIGITS'(1) << idx);
      o_dp      <= (gap || sup) ? 1'b0 : shadow_dp[idx];
      o_blank   <= gap || sup;
      o_ack     <= commit;
    end
  end

  assign ov_anode = AN_ACTIVE_LOW ? ~anode_oh : anode_oh;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (DIGITS=4, DIV=4, active-low anodes): frame-by-frame checks.
module tb_seg7_scan;

  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, lz_en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  nibble, anode;
  logic        dp, blank, ack;
  int          errs = 0, checks = 0, fr = 0;

  always #5 clk = ~clk;

  seg7_scan #(.DIGITS(4), .DIV(4), .AN_ACTIVE_LOW(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_load(load), .iv_value(value), .iv_dp(dp_in),
    .i_lz_en(lz_en), .ov_nibble(nibble), .ov_anode(anode), .o_dp(dp),
    .o_blank(blank), .o_ack(ack)
  );

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " anode"}, 16'(anode), 16'hF);
    chk({tag, " blank"}, 16'(blank), 16'h1);
    chk({tag, " ack"}, 16'(ack), 16'h0);
    chk({tag, " nibble"}, 16'(nibble), 16'h0);
    chk({tag, " dp"}, 16'(dp), 16'h0);
  endtask

  // Runs 16 cycles starting at digit 0's gap slot; step 16 lands on the frame-end ack slot.
  task automatic check_frame(input logic [15:0] nibs, input logic [3:0] dps, input logic [3:0] shown,
                             input logic ack_end, input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb, input logic [3:0] ldp);
    int d, c;
    logic g, s;
    logic [3:0] oh, e_an, e_nib;
    string t;
    for (int j = 1; j <= 16; j++) begin
      load  = (j == la) || (j == lb);
      value = (j == lb) ? vb : va;
      dp_in = ldp;
      step();
      load = 1'b0;
      d = (j - 1) / 4;
      c = (j - 1) % 4;
      g = (c == 0);
      s = !shown[d];
      oh = 4'b1 << d;
      e_an  = (g || s) ? 4'hF : ~oh;
      e_nib = s ? 4'h0 : nibs[4*d +: 4];
      t = $sformatf("f%0d s%0d", fr, j);
      chk({t, " anode"}, 16'(anode), 16'(e_an));
      chk({t, " nibble"}, 16'(nibble), 16'(e_nib));
      chk({t, " blank"}, 16'(blank), 16'(g || s));
      chk({t, " dp"}, 16'(dp), 16'((g || s) ? 1'b0 : dps[d]));
      chk({t, " ack"}, 16'(ack), 16'((j == 16) ? ack_end : 1'b0));
      if (!g && !s)
        chk({t, " seg7"}, 16'(seg7(nibble)), 16'(seg7(e_nib)));
    end
    fr++;
  endtask

  initial begin
    step();
    step();
    chk_reset("por");
    rst = 1'b0;

    // Load 1234 during frame 0; commit at its end.
    check_frame(16'h0000, 4'b0000, 4'hF, 1'b1, 1, 16'h1234, 0, 16'h0, 4'b0100);
    check_frame(16'h1234, 4'b0100, 4'hF, 1'b1, 2, 16'h0050, 0, 16'h0, 4'b0000);
    lz_en = 1'b1;
    check_frame(16'h0050, 4'b0000, 4'b0011, 1'b0, 0, 16'h0, 0, 16'h0, 4'b0000);
    lz_en = 1'b0;
    // Double load inside one frame: latest wins, single ack.
    check_frame(16'h0050, 4'b0000, 4'hF, 1'b1, 3, 16'hAAAA, 9, 16'hBBBB, 4'b0000);
    // Second load lands exactly on the commit edge.
    check_frame(16'hBBBB, 4'b0000, 4'hF, 1'b1, 5, 16'h1111, 16, 16'h2222, 4'b0000);
    check_frame(16'h1111, 4'b0000, 4'hF, 1'b1, 0, 16'h0, 0, 16'h0, 4'b0000);
    check_frame(16'h2222, 4'b0000, 4'hF, 1'b0, 0, 16'h0, 0, 16'h0, 4'b0000);

    // Mid-scan reset with a pending value that must be discarded.
    load = 1'b1; value = 16'h9999; dp_in = 4'b0000;
    step();
    load = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk_reset("rst0");
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_reset($sformatf("rst%0d", i));
    end
    rst = 1'b0;

    // Nibble sweep through all 16 values.
    check_frame(16'h0000, 4'b0000, 4'hF, 1'b1, 1, 16'h3210, 0, 16'h0, 4'b0000);
    check_frame(16'h3210, 4'b0000, 4'hF, 1'b1, 1, 16'h7654, 0, 16'h0, 4'b0000);
    check_frame(16'h7654, 4'b0000, 4'hF, 1'b1, 1, 16'hBA98, 0, 16'h0, 4'b0000);
    check_frame(16'hBA98, 4'b0000, 4'hF, 1'b1, 1, 16'hFEDC, 0, 16'h0, 4'b0000);
    check_frame(16'hFEDC, 4'b0000, 4'hF, 1'b0, 0, 16'h0, 0, 16'h0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
Multiplexed scanner for a DIGITS-wide common-anode 7-segment display. It sits directly upstream of the Seg7 decoder. It holds a multi-digit hex value and time-multiplexes one nibble at a time onto ov_nibble, which feeds Seg7, while driving the matching digit anode and decimal point. New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGITS, 4, number of digits; >=2
DIV, 1000, clock cycles each digit is selected; >=2
AN_ACTIVE_LOW, 1, 1: anode asserted = 0; 0: anode asserted = 1

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_load  input  1  strobe; capture iv_value/iv_dp into pending buffer
iv_value  input  4*DIGITS  hex value; digit k = bits [4k+3:4k], digit 0 least significant
iv_dp  input  DIGITS  decimal point per digit
i_lz_en  input  1  leading-zero suppression enable (level, sampled every cycle)
ov_nibble  output  4  current digit nibble, to Seg7 input
ov_anode  output  DIGITS  anode select, one-hot or all-off, polarity per AN_ACTIVE_LOW
o_dp  output  1  decimal point of current digit (active high)
o_blank  output  1  1 when the current slot shows nothing (gap cycle or suppressed digit)
o_ack  output  1  one-cycle pulse when a pending value is committed to display

Behaviour:
- Reset (async, immediate): prescaler=0, index=0, shadow value/dp=0, pending_valid=0.
- Outputs during reset: ov_nibble=0, ov_anode=all off, o_dp=0, o_blank=1, o_ack=0.
- Prescaler counts 0..DIV-1 and wraps. tick = (prescaler==DIV-1).
- On tick, index advances 0->1->...->DIGITS-1->0.
- Frame boundary = tick with index==DIGITS-1.
- All outputs are registered and reflect the (prescaler, index, shadow) values of the previous cycle: one cycle of latency.
- Gap cycle: when prescaler==0, anodes are all off, o_blank=1, and ov_nibble already carries the new digit's nibble. This is anti-ghosting.
- When prescaler!=0, the anode for the current index is asserted, ov_nibble=shadow digit[index], o_dp=shadow_dp[index], o_blank=0.
- Leading-zero suppression: with i_lz_en=1, digit k (k>=1) is suppressed if shadow digits k..DIGITS-1 are all zero. A suppressed digit has anode off, o_blank=1, o_dp=0, ov_nibble=0.
  - Digit 0 is never suppressed.
  - A digit whose dp=1 is not suppressed.
- i_load: pending <= {iv_value, iv_dp}, pending_valid <= 1. A later load before commit overwrites the pending value; the latest load wins and only one ack follows.
- Commit: at a frame boundary with pending_valid=1:
  - shadow <= pending, pending_valid <= 0.
  - o_ack=1 on the next cycle, for exactly one cycle.
  - The new value is first shown on digit 0 of the next frame.
- i_load coincident with a commit: the commit uses the old pending value; the new value becomes pending (pending_valid stays 1) and commits at the following frame boundary.
- Reset mid-frame: all state is cleared immediately, including pending. Scanning restarts at digit 0 with prescaler=0 after reset deasserts.
- The internal anode is one-hot; polarity is applied only at the output. At most one anode is ever asserted.

Test Plan:
- Reset: hold i_reset for 3 cycles mid-scan -> ov_anode=4'b1111, o_blank=1, o_ack=0, ov_nibble=0 while asserted. After release, the first asserted anode is 4'b1110.
- Basic scan (DIV=4, DIGITS=4, AN_ACTIVE_LOW=1): load 16'h1234, iv_dp=4'b0100.
  - o_ack pulses once after the first frame boundary.
  - Next frame nibbles 4,3,2,1 on anodes 1110,1101,1011,0111.
  - Each digit is 3 active cycles plus 1 gap cycle with anodes 1111.
  - o_dp=1 only while anode=1011.
- Leading-zero suppression: load 16'h0050, i_lz_en=1 -> digits 3 and 2 keep anodes at 1111 with o_blank=1; digit 1 shows 5; digit 0 shows 0. Set i_lz_en=0 -> all four digits are shown.
- Double load: load 16'hAAAA then 16'hBBBB in the same frame -> exactly one o_ack, and the display shows BBBB.
- Load on the commit cycle: pending 16'h1111, then load 16'h2222 exactly at the frame boundary.
  - 1111 is displayed next frame with one ack.
  - 2222 is displayed the frame after, with a second ack.
- Chained with Seg7: feed ov_nibble into Seg7 and sweep all 16 nibble values through iv_value -> Seg7 output matches its expected pattern for every active (non-gap) cycle.
